// File: rtl/triangle_cmd_fifo.sv
// Packs a byte stream into CMD_BYTES-wide commands (first byte = MSB) and
// buffers up to DEPTH of them behind a first-word-fall-through valid/ready port.
module triangle_cmd_fifo #(
  parameter int CMD_BYTES = 60,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             triangle_wrdata,
  input  logic                   triangle_push,
  output logic                   triangle_full,
  output logic [8*CMD_BYTES-1:0] cmd_data,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_is_efb,
  output logic                   cmd_is_ef,
  output logic [ADDR_W:0]        level,
  output logic                   overflow
);

  localparam int CMD_W   = 8 * CMD_BYTES;
  localparam int CNT_W   = $clog2(CMD_BYTES);
  localparam int EFB_BIT = 247;
  localparam int EF_BIT  = 246;

  logic [CNT_W-1:0]  byte_cnt_reg;
  logic [CMD_W-9:0]  asm_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   level_reg;
  logic              overflow_reg;
  logic [CMD_W-1:0]  mem_reg [DEPTH];

  logic             last_byte;
  logic             commit;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic [CMD_W-1:0] wr_word;

  assign last_byte = (byte_cnt_reg == CNT_W'(CMD_BYTES - 1));
  assign commit    = triangle_push && last_byte;
  assign full      = (level_reg == (ADDR_W+1)'(DEPTH));
  assign cmd_valid = (level_reg != '0);
  assign pop       = cmd_valid && cmd_ready;
  // A commit into a full FIFO still lands if the head leaves on the same edge.
  assign wr_en     = commit && (!full || pop);
  assign wr_word   = {asm_reg, triangle_wrdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (triangle_push) begin
        asm_reg      <= wr_word[CMD_W-9:0];
        byte_cnt_reg <= last_byte ? '0 : byte_cnt_reg + 1'b1;
      end
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !pop)      level_reg <= level_reg + 1'b1;
      else if (!wr_en && pop) level_reg <= level_reg - 1'b1;
      if (commit && !wr_en) overflow_reg <= 1'b1;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg] <= wr_word;
  end

  assign cmd_data      = mem_reg[rd_ptr_reg];
  assign cmd_is_efb    = cmd_valid && cmd_data[EFB_BIT];
  assign cmd_is_ef     = cmd_valid && cmd_data[EF_BIT];
  assign triangle_full = full;
  assign level         = level_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_triangle_cmd_fifo.sv
// Self-checking bench for triangle_cmd_fifo: queue-based reference model checked
// every cycle, a flag-decode vector table and directed corner-case sequences.
module tb_triangle_cmd_fifo;

  localparam int CB    = 60;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = 8 * CB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    wrdata = 8'h00;
  logic          push = 1'b0;
  logic          full;
  logic [W-1:0]  cmd_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic          efb;
  logic          ef;
  logic [AW:0]   level;
  logic          overflow;

  always #5 clk = ~clk;

  triangle_cmd_fifo #(.CMD_BYTES(CB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .triangle_wrdata(wrdata), .triangle_push(push), .triangle_full(full),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_efb(efb), .cmd_is_ef(ef), .level(level), .overflow(overflow)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_pops = 0;
  int n_commits = 0;

  // Reference model: whole commands in a queue, the partial one as a byte list.
  logic [W-1:0] mq[$];
  logic [7:0]   part[$];
  logic         m_ovf = 1'b0;

  typedef struct {
    logic [7:0] b29;
    logic       exp_efb;
    logic       exp_ef;
  } flag_vec_t;
  flag_vec_t fv[5];

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    cmp("valid", W'(cmd_valid), W'(mq.size() != 0));
    cmp("level", W'(level), W'(mq.size()));
    cmp("full", W'(full), W'(mq.size() == DEPTH));
    cmp("overflow", W'(overflow), W'(m_ovf));
    if (mq.size() != 0) cmp("head_data", cmd_data, head);
    cmp("efb", W'(efb), W'(head[247]));
    cmp("ef", W'(ef), W'(head[246]));
  endtask

  // One clock: apply inputs, advance the model by the same edge, then check.
  task automatic step(input logic p, input logic [7:0] d, input logic r);
    bit           do_pop, do_commit, was_full;
    logic [W-1:0] w;
    push = p; wrdata = d; cmd_ready = r;
    do_pop    = r && (mq.size() != 0);
    do_commit = p && (part.size() == CB - 1);
    was_full  = (mq.size() == DEPTH);
    w = '0;
    if (p) part.push_back(d);
    if (do_commit) begin
      for (int i = 0; i < CB; i++) w[W-1-8*i -: 8] = part[i];
      part.delete();
    end
    if (do_pop) begin
      void'(mq.pop_front());
      n_pops++;
      $display("pop    #%0d", n_pops);
    end
    if (do_commit) begin
      n_commits++;
      if (was_full && !do_pop) m_ovf = 1'b1;
      else mq.push_back(w);
      $display("commit #%0d dropped=%0d stored=%0d", n_commits, was_full && !do_pop, mq.size());
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    check_all();
  endtask

  task automatic push_cmd(input logic [7:0] base, input int b29, input logic r,
                          input logic r_last, input int gmax, output logic [W-1:0] word);
    logic [7:0] d;
    word = '0;
    for (int i = 0; i < CB; i++) begin
      d = base + 8'(i);
      if (i == 29 && b29 >= 0) d = 8'(b29);
      word[W-1-8*i -: 8] = d;
      repeat ($urandom_range(0, gmax)) step(1'b0, 8'h00, r);
      step(1'b1, d, (i == CB - 1) ? r_last : r);
    end
  endtask

  // Called just after an edge; checks that reset acts before the next edge.
  task automatic do_reset();
    push = 1'b0; cmd_ready = 1'b0; rst = 1'b1;
    #1;
    cmp("rst_async_valid", W'(cmd_valid), W'(0));
    cmp("rst_async_level", W'(level), W'(0));
    cmp("rst_async_full", W'(full), W'(0));
    cmp("rst_async_ovf", W'(overflow), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); part.delete(); m_ovf = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w, w5, head, last;
    int guard;

    fv[0] = '{8'h80, 1'b1, 1'b0};
    fv[1] = '{8'h40, 1'b0, 1'b1};
    fv[2] = '{8'hC0, 1'b1, 1'b1};
    fv[3] = '{8'h3F, 1'b0, 1'b0};
    fv[4] = '{8'h00, 1'b0, 1'b0};

    #2;
    do_reset();

    // Single command, first byte lands in the MSB.
    push_cmd(8'h00, -1, 1'b0, 1'b0, 0, w);
    cmp("t1_valid", W'(cmd_valid), W'(1));
    cmp("t1_msb", W'(cmd_data[479:472]), W'(8'h00));
    cmp("t1_lsb", W'(cmd_data[7:0]), W'(8'h3B));
    cmp("t1_level", W'(level), W'(1));

    // Flag decode table on byte 29.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      push_cmd(8'h10, int'(fv[i].b29), 1'b0, 1'b0, 0, w);
      cmp("t2_efb", W'(efb), W'(fv[i].exp_efb));
      cmp("t2_ef", W'(ef), W'(fv[i].exp_ef));
    end

    // Fill to DEPTH, then a single pop.
    do_reset();
    for (int k = 0; k < DEPTH; k++) push_cmd(8'(k * 16), -1, 1'b0, 1'b0, 0, w);
    cmp("t3_full", W'(full), W'(1));
    cmp("t3_level4", W'(level), W'(4));
    step(1'b0, 8'h00, 1'b1);
    cmp("t3_full_after_pop", W'(full), W'(0));
    cmp("t3_level3", W'(level), W'(3));

    // Overflow: commit into a full FIFO with no pop is dropped.
    push_cmd(8'h70, -1, 1'b0, 1'b0, 0, w);
    head = cmd_data;
    push_cmd(8'hA0, -1, 1'b0, 1'b0, 0, w);
    cmp("t4_overflow", W'(overflow), W'(1));
    cmp("t4_level", W'(level), W'(4));
    cmp("t4_head_kept", cmd_data, head);

    // Commit into a full FIFO with a simultaneous pop is accepted.
    do_reset();
    for (int k = 0; k < DEPTH; k++) push_cmd(8'(k * 16 + 1), -1, 1'b0, 1'b0, 0, w);
    push_cmd(8'hC5, -1, 1'b0, 1'b1, 0, w5);
    cmp("t4b_no_overflow", W'(overflow), W'(0));
    cmp("t4b_level", W'(level), W'(4));
    last = '0;
    guard = 0;
    while (cmd_valid && guard < 10) begin
      last = cmd_data;
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    cmp("t4b_drained", W'(level), W'(0));
    cmp("t4b_last_is_5th", last, w5);

    // Reset in the middle of a command discards the partial bytes.
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 8'hAA, 1'b0);
    do_reset();
    push_cmd(8'h40, -1, 1'b0, 1'b0, 0, w);
    cmp("t5_level", W'(level), W'(1));
    cmp("t5_clean", cmd_data, w);

    // Back-to-back commands with random byte gaps and an always-ready consumer.
    do_reset();
    n_pops = 0;
    for (int k = 0; k < 10; k++) push_cmd(8'($urandom_range(0, 255)), -1, 1'b1, 1'b1, 3, w);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    cmp("t6_pops", W'(n_pops), W'(10));
    cmp("t6_overflow", W'(overflow), W'(0));
    cmp("t6_empty", W'(cmd_valid), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
